// File: rtl/pwm_sched_pkg.sv
// Shared types and helpers for the time-multiplexed PWM voice scheduler.
package pwm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  localparam logic CFG_SEL_FREQ = 1'b0;
  localparam logic CFG_SEL_DUTY = 1'b1;

  function automatic int slot_w(input int voices);
    return (voices < 2) ? 1 : $clog2(voices);
  endfunction

endpackage

// File: rtl/voice_regfile.sv
// Per-voice freq/duty/phase storage: one issue read port with phase-increment
// writeback and one config write port. Reads return pre-edge values.
module voice_regfile
  import pwm_sched_pkg::*;
#(
  parameter int N       = 14,
  parameter int M       = 12,
  parameter int VOICES  = 4,
  localparam int SW     = slot_w(VOICES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_en,
  input  logic [SW-1:0] iss_slot,
  output logic [N-1:0]  iss_phase,
  output logic [M-1:0]  iss_duty,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_voice,
  input  logic          wr_sel,
  input  logic [N-1:0]  wr_data
);

  logic [N-1:0] phase_q [VOICES];
  logic [N-1:0] phase_d [VOICES];
  logic [N-1:0] freq_q  [VOICES];
  logic [N-1:0] freq_d  [VOICES];
  logic [M-1:0] duty_q  [VOICES];
  logic [M-1:0] duty_d  [VOICES];

  assign iss_phase = phase_q[iss_slot];
  assign iss_duty  = duty_q[iss_slot];

  // Increment uses the pre-write freq, so a same-edge config write lands next frame.
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      phase_d[v] = phase_q[v];
      freq_d[v]  = freq_q[v];
      duty_d[v]  = duty_q[v];
    end
    if (iss_en) begin
      phase_d[iss_slot] = phase_q[iss_slot] + freq_q[iss_slot];
    end
    if (wr_en) begin
      if (wr_sel == CFG_SEL_DUTY) begin
        duty_d[wr_voice] = wr_data[M-1:0];
      end else begin
        freq_d[wr_voice] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VOICES; v++) begin
        phase_q[v] <= '0;
        freq_q[v]  <= '0;
        duty_q[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        phase_q[v] <= phase_d[v];
        freq_q[v]  <= freq_d[v];
        duty_q[v]  <= duty_d[v];
      end
    end
  end

endmodule

// File: rtl/pwm_voice_sched.sv
// Round-robin scheduler sharing one registered PWM comparator among VOICES voices.
// Build macro PWM_SCHED_MUTE_EN adds a per-voice mute input sampled at issue.
module pwm_voice_sched
  import pwm_sched_pkg::*;
#(
  parameter int N       = 14,
  parameter int M       = 12,
  parameter int VOICES  = 4,
  localparam int SW     = slot_w(VOICES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [SW-1:0] cfg_voice,
  input  logic          cfg_sel,
  input  logic [N-1:0]  cfg_data,
  output logic [N-1:0]  dp_phase,
  output logic [M-1:0]  dp_mod,
  input  logic [M-1:0]  dp_pwm,
  output logic [M-1:0]  mix_out,
  output logic          mix_valid
`ifdef PWM_SCHED_MUTE_EN
  ,
  input  logic [VOICES-1:0] mute
`endif
);

  localparam logic [SW-1:0] LAST_SLOT = SW'(VOICES - 1);
  localparam int            AW        = M + SW;

  sched_state_e  state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          issue;
  logic [SW-1:0] iss_slot;
  logic          last_issue;
  logic          apply;
  logic          iss_mute;
  logic [N-1:0]  rf_phase;
  logic [M-1:0]  rf_duty;

  logic          pend_vld_q, pend_vld_d;
  logic [SW-1:0] pend_voice_q, pend_voice_d;
  logic          pend_sel_q, pend_sel_d;
  logic [N-1:0]  pend_data_q, pend_data_d;

  logic [N-1:0]  dp_phase_q, dp_phase_d;
  logic [M-1:0]  dp_mod_q, dp_mod_d;

  logic          vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic [SW-1:0] tag_p0_q, tag_p0_d, tag_p1_q, tag_p1_d;
  logic          mute_p0_q, mute_p0_d, mute_p1_q, mute_p1_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] sum;
  logic [M-1:0]  pwm_term;
  logic [M-1:0]  mix_out_q, mix_out_d;
  logic          mix_valid_q, mix_valid_d;

`ifdef PWM_SCHED_MUTE_EN
  assign iss_mute = mute[iss_slot];
`else
  assign iss_mute = 1'b0;
`endif

  // slot_q is the next slot to issue while in RUN/DRAIN.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    issue    = 1'b0;
    iss_slot = slot_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          issue    = 1'b1;
          iss_slot = '0;
          slot_d   = SW'(1);
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        issue  = 1'b1;
        slot_d = slot_q + 1'b1;
        if (slot_q == LAST_SLOT) begin
          state_d = enable ? ST_RUN : ST_IDLE;
        end else if (!enable) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        issue  = 1'b1;
        slot_d = slot_q + 1'b1;
        if (slot_q == LAST_SLOT) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    last_issue = issue && (iss_slot == LAST_SLOT);
  end

  // Config writes land only at frame boundaries while running.
  assign cfg_ready = ~pend_vld_q;
  assign apply     = pend_vld_q && ((state_q == ST_IDLE) || last_issue);

  always_comb begin
    pend_vld_d   = pend_vld_q;
    pend_voice_d = pend_voice_q;
    pend_sel_d   = pend_sel_q;
    pend_data_d  = pend_data_q;
    if (apply) begin
      pend_vld_d = 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      pend_vld_d   = 1'b1;
      pend_voice_d = cfg_voice;
      pend_sel_d   = cfg_sel;
      pend_data_d  = cfg_data;
    end
  end

  voice_regfile #(
    .N      (N),
    .M      (M),
    .VOICES (VOICES)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_en    (issue),
    .iss_slot  (iss_slot),
    .iss_phase (rf_phase),
    .iss_duty  (rf_duty),
    .wr_en     (apply),
    .wr_voice  (pend_voice_q),
    .wr_sel    (pend_sel_q),
    .wr_data   (pend_data_q)
  );

  // Stage p0: issue register feeding the shared datapath.
  always_comb begin
    dp_phase_d = issue ? rf_phase : dp_phase_q;
    dp_mod_d   = issue ? rf_duty : '0;
    vld_p0_d   = issue;
    tag_p0_d   = iss_slot;
    mute_p0_d  = iss_mute;
  end

  // Stage p1: datapath registers its result; p2 capture into the frame accumulator.
  always_comb begin
    vld_p1_d    = vld_p0_q;
    tag_p1_d    = tag_p0_q;
    mute_p1_d   = mute_p0_q;
    pwm_term    = mute_p1_q ? '0 : dp_pwm;
    sum         = acc_q + AW'(pwm_term);
    acc_d       = acc_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    if (vld_p1_q) begin
      if (tag_p1_q == LAST_SLOT) begin
        mix_out_d   = sum[AW-1:SW];
        mix_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      pend_vld_q   <= 1'b0;
      pend_voice_q <= '0;
      pend_sel_q   <= 1'b0;
      pend_data_q  <= '0;
      dp_phase_q   <= '0;
      dp_mod_q     <= '0;
      vld_p0_q     <= 1'b0;
      tag_p0_q     <= '0;
      mute_p0_q    <= 1'b0;
      vld_p1_q     <= 1'b0;
      tag_p1_q     <= '0;
      mute_p1_q    <= 1'b0;
      acc_q        <= '0;
      mix_out_q    <= '0;
      mix_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      pend_vld_q   <= pend_vld_d;
      pend_voice_q <= pend_voice_d;
      pend_sel_q   <= pend_sel_d;
      pend_data_q  <= pend_data_d;
      dp_phase_q   <= dp_phase_d;
      dp_mod_q     <= dp_mod_d;
      vld_p0_q     <= vld_p0_d;
      tag_p0_q     <= tag_p0_d;
      mute_p0_q    <= mute_p0_d;
      vld_p1_q     <= vld_p1_d;
      tag_p1_q     <= tag_p1_d;
      mute_p1_q    <= mute_p1_d;
      acc_q        <= acc_d;
      mix_out_q    <= mix_out_d;
      mix_valid_q  <= mix_valid_d;
    end
  end

  assign dp_phase  = dp_phase_q;
  assign dp_mod    = dp_mod_q;
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;

endmodule

// File: doc/pwm_voice_sched.md
# pwm_voice_sched

Time-multiplexing scheduler that shares one registered PWM comparator datapath among `VOICES` synthesizer voices. Per voice, it holds the phase accumulator, frequency increment and duty value. Each cycle it issues one voice's phase/duty pair to the shared datapath and collects the 1-bit-wide (replicated) result two edges later. Once per frame it emits an averaged mix sample to the DAC/output stage.

## Interface
- `N`, 14: phase accumulator width.
- `M`, 12: duty/waveform width; compare uses `phase[N-1:N-M]`.
- `VOICES`, 4: voice count; power of two, ≥2.
- `clk` in 1: system clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `enable` in 1: run request; level-sensitive.
- `cfg_valid` in 1: config write request.
- `cfg_ready` out 1: config slot free.
- `cfg_voice` in log2(VOICES): target voice.
- `cfg_sel` in 1: 0 = frequency increment (`cfg_data[N-1:0]`), 1 = duty (`cfg_data[M-1:0]`).
- `cfg_data` in N: write data.
- `dp_phase` out N: phase to shared datapath (registered).
- `dp_mod` out M: duty to shared datapath (registered).
- `dp_pwm` in M: datapath result, registered inside datapath (1 edge after `dp_*`).
- `mix_out` out M: averaged mix sample.
- `mix_valid` out 1: one-cycle strobe, `mix_out` new.

## Operation
- FSM states:
  - IDLE: `dp_mod`=0, no issue.
  - RUN: issue one slot per cycle, round-robin 0..VOICES-1.
  - DRAIN: finish the current frame, then go to IDLE.
- IDLE→RUN: at the edge where `enable`=1; slot 0 issues on that edge.
- RUN→DRAIN: `enable`=0 sampled with slot≠VOICES-1. Remaining slots of the frame still issue.
- RUN→IDLE: `enable`=0 when slot VOICES-1 issues. DRAIN→IDLE happens on that same edge.
- Issue of slot s loads `dp_phase`←`phase[s]` (pre-increment) and `dp_mod`←`duty[s]`, and updates `phase[s]`←`phase[s]+freq[s]` mod 2^N. Wrap-around is silent.
- A 2-deep tag/valid pipe tracks in-flight slots. `dp_pwm` is sampled 2 edges after issue and added into an accumulator of M+log2(VOICES) bits.
- On capture of the slot VOICES-1 result:
  - `mix_out`←(acc + `dp_pwm`)>>log2(VOICES). Truncating average, no overflow possible.
  - `mix_valid`=1 for one cycle.
  - Accumulator clears.
- Config handshake: a transfer occurs when `cfg_valid`&`cfg_ready` at an edge. The write is captured into a one-entry pending register and `cfg_ready` drops.
  - In IDLE, the pending write applies on the next edge.
  - In RUN/DRAIN, it applies on the edge issuing slot VOICES-1, so no voice changes mid-frame.
  - `cfg_ready` rises the cycle after the apply.
- Apply coinciding with issue of the same voice: the issue uses the old value; the new value takes effect next frame.
- `phase[]` is never written by config. It clears only on reset.
- Reset (any time, including mid-frame):
  - All `phase`/`freq`/`duty` = 0; accumulator and in-flight pipe cleared.
  - `dp_phase`=0, `dp_mod`=0, `mix_out`=0, `mix_valid`=0, `cfg_ready`=1, pending empty, state IDLE.

## Timing
- Enable sampled at edge e: slot s issues at e+s and its result is captured at e+s+2.
- First `mix_valid` is high after edge e+VOICES+1.
- Steady state: `mix_valid` every VOICES cycles.
- Config apply latency: 1–VOICES cycles after handshake.
- Throughput: one config write per frame in RUN.

## Configuration
- `PWM_SCHED_MUTE_EN` defined:
  - Adds input `mute` [VOICES-1:0], sampled at issue.
  - A muted slot adds 0 to the accumulator; its phase still advances.
- `PWM_SCHED_MUTE_EN` undefined: the port is absent and all voices contribute.

## Structure
- Package `pwm_sched_pkg`: FSM state enum (IDLE/RUN/DRAIN), `cfg_sel` encodings, slot-width localparam function.
- Sub-module `voice_regfile`: per-voice `freq`/`duty`/`phase` storage with one issue read port, phase-increment writeback and config write port.

## Test plan
- All `duty`=0, `enable`=1 → `mix_out`=0 every frame. `mix_valid` period 4, first high after edge e+5.
- All `freq`=0, voices 0,1 `duty`=4095, voices 2,3 `duty`=0 → `mix_out`=2047 (8190>>2).
- Voice 0 `freq`=0x3FFF → `dp_phase` for slot 0 follows the sequence 0, 0x3FFF, 0x3FFE (wrap, no stall).
- Config write with `cfg_valid` held 3 frames during RUN → exactly 1 transfer per frame. Value visible at the next frame's issue; `cfg_ready` low 1–4 cycles.
- `enable` drops after slot 1 issue → slots 2,3 still issue, one final `mix_valid`, then IDLE with `dp_mod`=0.
- `rst_n` low mid-frame → all outputs at reset values immediately, no `mix_valid`. Restart yields the same sequence as the first enable.
